// File: rtl/ipf_seq_ctrl.sv
// ipf_seq_ctrl: sequences one filter job for the IPF engine.
// A job loads the kernel weights, then runs npass passes. Each pass is a PRE
// (hold) phase followed by a RUN (start) phase. The block then waits in DRAIN
// for the engine to report completion.
// Optional feature: define IPF_SEQ_TIMEOUT_EN to bound the DRAIN wait at 1023
// cycles. On timeout the block pulses done and raises a sticky err.
module ipf_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_start,
  input  logic        cfg_wsize,
  input  logic        cfg_stride,
  input  logic [3:0]  cfg_npass,
  input  logic        w_src_valid,
  input  logic [63:0] w_src_data,
  output logic        w_src_ready,
  input  logic        i_src_valid,
  input  logic [63:0] i_src_data,
  output logic        i_src_ready,
  output logic [1:0]  ipf_ctrl,
  output logic        ipf_w_valid,
  output logic [63:0] ipf_w_data,
  output logic        ipf_i_valid,
  output logic [63:0] ipf_i_data,
  output logic [1:0]  ipf_Wsize,
  output logic        ipf_stride,
  output logic [3:0]  ipf_wgroup,
  output logic [2:0]  ipf_wround,
  input  logic        ipf_finish,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {S_IDLE, S_WLOAD, S_PRE, S_RUN, S_DRAIN} state_t;

  state_t      r_state, w_state_next;
  logic        r_wsize, r_stride;
  logic [3:0]  r_npass, r_pass;
  logic [4:0]  r_cnt;
  logic [4:0]  w_cnt_max;
  logic        w_w_hs, w_i_hs, w_cnt_last, w_last_pass, w_timeout;
  logic [1:0]  r_ctrl;
  logic        r_w_valid, r_i_valid, r_done;
  logic [63:0] r_w_data, r_i_data;
  logic [3:0]  r_wgroup;
  logic [2:0]  r_wround;

  // Ready is gated by rst so no source word is consumed during the reset cycle.
  assign w_src_ready = (r_state == S_WLOAD) && !rst;
  assign i_src_ready = ((r_state == S_PRE) || (r_state == S_RUN)) && !rst;
  assign w_w_hs      = w_src_valid && w_src_ready;
  assign w_i_hs      = i_src_valid && i_src_ready;
  assign w_cnt_last  = (r_cnt == w_cnt_max);
  assign w_last_pass = (r_pass == (r_npass - 4'd1));

  // Last word index of the current phase, which depends on the kernel size.
  always_comb begin
    w_cnt_max = 5'd0;
    case (r_state)
      S_WLOAD: w_cnt_max = r_wsize ? 5'd24 : 5'd17;
      S_PRE:   w_cnt_max = r_wsize ? 5'd3  : 5'd1;
      S_RUN:   w_cnt_max = r_wsize ? 5'd3  : 5'd13;
      default: w_cnt_max = 5'd0;
    endcase
  end

`ifdef IPF_SEQ_TIMEOUT_EN
  logic [9:0] r_tmo;
  logic       r_err;

  // r_tmo holds k in the (k+1)-th DRAIN cycle, so 1022 marks the 1023rd cycle.
  // done/err become visible exactly 1023 cycles after DRAIN is entered.
  assign w_timeout = (r_state == S_DRAIN) && !ipf_finish && (r_tmo == 10'd1022);
  assign err       = r_err;

  // DRAIN cycle counter; cleared whenever the FSM is elsewhere.
  always_ff @(posedge clk) begin
    if (rst || (r_state != S_DRAIN)) r_tmo <= 10'd0;
    else                             r_tmo <= r_tmo + 10'd1;
  end

  // Sticky timeout flag, cleared only by the next accepted job start.
  always_ff @(posedge clk) begin
    if (rst)                                   r_err <= 1'b0;
    else if ((r_state == S_IDLE) && cfg_start) r_err <= 1'b0;
    else if (w_timeout)                        r_err <= 1'b1;
  end
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic. Phases advance on the handshake of their last word.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (cfg_start) w_state_next = S_WLOAD;
      S_WLOAD: if (w_w_hs && w_cnt_last) w_state_next = S_PRE;
      S_PRE:   if (w_i_hs && w_cnt_last) w_state_next = S_RUN;
      S_RUN:   if (w_i_hs && w_cnt_last) w_state_next = w_last_pass ? S_DRAIN : S_PRE;
      S_DRAIN: if (ipf_finish || w_timeout) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Job configuration, word and pass counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wsize  <= 1'b0;
      r_stride <= 1'b0;
      r_npass  <= 4'd0;
      r_pass   <= 4'd0;
      r_cnt    <= 5'd0;
    end else if (r_state == S_IDLE) begin
      r_pass <= 4'd0;
      r_cnt  <= 5'd0;
      if (cfg_start) begin
        r_wsize  <= cfg_wsize;
        r_stride <= cfg_stride && !cfg_wsize;  // stride 2 exists only for 3x3
        r_npass  <= (cfg_npass == 4'd0) ? 4'd1 : cfg_npass;
      end
    end else if (w_w_hs || w_i_hs) begin
      if (w_cnt_last) begin
        r_cnt <= 5'd0;
        if (r_state == S_RUN) r_pass <= r_pass + 4'd1;
      end else begin
        r_cnt <= r_cnt + 5'd1;
      end
    end
  end

  // Registered engine-side outputs. ctrl is delayed along with the data,
  // so each forwarded word carries the command of the phase that accepted it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl    <= 2'd0;
      r_w_valid <= 1'b0;
      r_w_data  <= 64'd0;
      r_i_valid <= 1'b0;
      r_i_data  <= 64'd0;
      r_done    <= 1'b0;
    end else begin
      r_w_valid <= w_w_hs;
      r_i_valid <= w_i_hs;
      if (w_w_hs) r_w_data <= w_src_data;
      if (w_i_hs) r_i_data <= i_src_data;
      r_done    <= (r_state == S_DRAIN) && (ipf_finish || w_timeout);
      case (r_state)
        S_PRE:   r_ctrl <= 2'd2;
        S_RUN:   r_ctrl <= 2'd1;
        default: r_ctrl <= 2'd0;
      endcase
    end
  end

  // Per-pass sideband. It updates with the first PRE word so the change lines
  // up with that word on the engine side. In stride-2 mode, bit 0 follows the
  // RUN word parity.
  always_ff @(posedge clk) begin
    if (rst || ((r_state == S_IDLE) && cfg_start)) begin
      r_wgroup <= 4'd0;
      r_wround <= 3'd0;
    end else if ((r_state == S_PRE) && w_i_hs && (r_cnt == 5'd0)) begin
      r_wgroup <= (r_wsize || r_stride) ? 4'd0 : r_pass;
      r_wround <= r_wsize ? {2'b00, r_pass[0]} : 3'd0;
    end else if ((r_state == S_RUN) && w_i_hs && r_stride) begin
      r_wgroup <= {3'b000, r_cnt[0]};
    end
  end

  assign ipf_ctrl    = r_ctrl;
  assign ipf_w_valid = r_w_valid;
  assign ipf_w_data  = r_w_data;
  assign ipf_i_valid = r_i_valid;
  assign ipf_i_data  = r_i_data;
  assign ipf_Wsize   = {1'b0, r_wsize};
  assign ipf_stride  = r_stride;
  assign ipf_wgroup  = r_wgroup;
  assign ipf_wround  = r_wround;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;

endmodule

// File: tb/tb_ipf_seq_ctrl.sv
// Directed testbench for ipf_seq_ctrl.
// Words are numbered from a fixed base so that loss or duplication shows up.
module tb_ipf_seq_ctrl;

  localparam logic [63:0] W_BASE = 64'h1000_0000_0000_0000;
  localparam logic [63:0] I_BASE = 64'h2000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst, cfg_start, cfg_wsize, cfg_stride;
  logic [3:0]  cfg_npass;
  logic        w_src_valid, w_src_ready, i_src_valid, i_src_ready;
  logic [63:0] w_src_data, i_src_data;
  logic [1:0]  ipf_ctrl;
  logic        ipf_w_valid, ipf_i_valid;
  logic [63:0] ipf_w_data, ipf_i_data;
  logic [1:0]  ipf_Wsize;
  logic        ipf_stride;
  logic [3:0]  ipf_wgroup;
  logic [2:0]  ipf_wround;
  logic        ipf_finish, busy, done, err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int w_seq, i_seq, cap_w_n, w_bad_n, done_n, first_cyc, last_cyc;
  logic [63:0] cap_d[$];
  logic [1:0]  cap_c[$];
  logic [3:0]  cap_g[$];
  logic [2:0]  cap_r[$];

  ipf_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_wsize(cfg_wsize), .cfg_stride(cfg_stride), .cfg_npass(cfg_npass),
    .w_src_valid(w_src_valid), .w_src_data(w_src_data), .w_src_ready(w_src_ready),
    .i_src_valid(i_src_valid), .i_src_data(i_src_data), .i_src_ready(i_src_ready),
    .ipf_ctrl(ipf_ctrl), .ipf_w_valid(ipf_w_valid), .ipf_w_data(ipf_w_data),
    .ipf_i_valid(ipf_i_valid), .ipf_i_data(ipf_i_data),
    .ipf_Wsize(ipf_Wsize), .ipf_stride(ipf_stride), .ipf_wgroup(ipf_wgroup), .ipf_wround(ipf_wround),
    .ipf_finish(ipf_finish), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // One clock: note handshakes before the edge, then advance the source data
  // and record the engine-side outputs 1 time unit after the edge.
  task automatic step();
    logic hw, hi;
    hw = w_src_valid && w_src_ready;
    hi = i_src_valid && i_src_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (hw) begin w_seq++; w_src_data = W_BASE + 64'(w_seq); end
    if (hi) begin i_seq++; i_src_data = I_BASE + 64'(i_seq); end
    if (ipf_w_valid) begin
      if (ipf_w_data !== W_BASE + 64'(cap_w_n)) w_bad_n++;
      cap_w_n++;
    end
    if (ipf_i_valid) begin
      if (cap_d.size() == 0) first_cyc = cyc;
      last_cyc = cyc;
      cap_d.push_back(ipf_i_data);
      cap_c.push_back(ipf_ctrl);
      cap_g.push_back(ipf_wgroup);
      cap_r.push_back(ipf_wround);
    end
    if (done === 1'b1) done_n++;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_start = 1'b0; cfg_wsize = 1'b0; cfg_stride = 1'b0; cfg_npass = 4'd0;
    w_src_valid = 1'b0; i_src_valid = 1'b0; w_src_data = '0; i_src_data = '0; ipf_finish = 1'b0;
    w_seq = 0; i_seq = 0; cap_w_n = 0; w_bad_n = 0; done_n = 0;
    repeat (3) step();
    total++;
    if ({w_src_ready, i_src_ready, ipf_ctrl, ipf_w_valid, ipf_i_valid, ipf_w_data, ipf_i_data,
         ipf_Wsize, ipf_stride, ipf_wgroup, ipf_wround, busy, done, err} !== '0)
      $display("FAIL reset_outputs: got ctrl=%0d busy=%b done=%b err=%b wr=%b ir=%b want all 0",
               ipf_ctrl, busy, done, err, w_src_ready, i_src_ready);
    rst = 1'b0;
    w_src_valid = 1'b1; i_src_valid = 1'b1;
    step();
    total++;
    if ({busy, w_src_ready, i_src_ready} !== 3'b000)
      $display("FAIL idle_after_reset: got busy=%b wr=%b ir=%b want 0 0 0", busy, w_src_ready, i_src_ready);
  endtask

  // Start a job with sources valid. Run until every expected input word has
  // come out, check the word stream, then step once into DRAIN.
  // gap_at >= 0 drops i_src_valid for 3 cycles after that many input words.
  // nz injects a stray ipf_finish and a stray cfg_start mid-job.
  task automatic run_to_drain(input logic ws, input logic st, input logic [3:0] np,
                              input int gap_at, input int gap_exp, input logic nz);
    int pre_n, run_n, npe, exp_i, gap_left, n, bad_d, bad_c, bad_s, bub, p, j;
    logic gap_done;
    logic [1:0] ec;
    pre_n = ws ? 4 : 2;
    run_n = ws ? 4 : 14;
    npe   = (np == 4'd0) ? 1 : int'(np);
    exp_i = npe * (pre_n + run_n);
    cap_d.delete(); cap_c.delete(); cap_g.delete(); cap_r.delete();
    w_seq = 0; i_seq = 0; cap_w_n = 0; w_bad_n = 0; done_n = 0; first_cyc = 0; last_cyc = 0;
    w_src_data = W_BASE; i_src_data = I_BASE;
    w_src_valid = 1'b1; i_src_valid = 1'b1;
    cfg_wsize = ws; cfg_stride = st; cfg_npass = np; cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    total++;
    if (busy !== 1'b1) $display("FAIL busy_after_start: got %b want 1", busy);
    n = 0; gap_left = 0; gap_done = 1'b0;
    while (cap_d.size() < exp_i && n < 3000) begin
      if (!gap_done && gap_at >= 0 && i_seq == gap_at) begin gap_left = 3; gap_done = 1'b1; end
      i_src_valid = (gap_left == 0);
      if (gap_left > 0) gap_left--;
      ipf_finish = nz && (n == 5 || n == 30);
      cfg_start  = nz && (n == 30);
      cfg_wsize  = (nz && n == 30) ? ~ws : ws;
      step();
      n++;
    end
    ipf_finish = 1'b0; cfg_start = 1'b0; cfg_wsize = ws; i_src_valid = 1'b1;
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL job_timeout: got %0d input words want %0d", cap_d.size(), exp_i);
    end
    total++;
    if (cap_w_n != (ws ? 25 : 18)) begin bad++; $display("FAIL w_count: got %0d want %0d", cap_w_n, ws ? 25 : 18); end
    total++;
    if (w_bad_n != 0) begin bad++; $display("FAIL w_data: got %0d wrong words want 0", w_bad_n); end
    total++;
    if (cap_d.size() != exp_i) begin bad++; $display("FAIL i_count: got %0d want %0d", cap_d.size(), exp_i); end
    bad_d = 0; bad_c = 0; bad_s = 0;
    for (int k = 0; k < cap_d.size(); k++) begin
      p  = k / (pre_n + run_n);
      j  = k % (pre_n + run_n);
      ec = (j < pre_n) ? 2'd2 : 2'd1;
      if (cap_d[k] !== I_BASE + 64'(k)) bad_d++;
      if (cap_c[k] !== ec) bad_c++;
      if (!ws && !st && cap_g[k] !== 4'(p)) bad_s++;
      if (!ws && st && j >= pre_n && cap_g[k][0] !== 1'((j - pre_n) % 2)) bad_s++;
      if (ws && cap_r[k] !== 3'(p % 2)) bad_s++;
    end
    total++;
    if (bad_d != 0) begin bad++; $display("FAIL i_data: got %0d wrong words want 0", bad_d); end
    total++;
    if (bad_c != 0) begin bad++; $display("FAIL i_ctrl: got %0d words with wrong ctrl want 0", bad_c); end
    total++;
    if (bad_s != 0) begin bad++; $display("FAIL sideband: got %0d words with wrong wgroup/wround want 0", bad_s); end
    bub = last_cyc - first_cyc + 1 - cap_d.size();
    total++;
    if (bub != gap_exp) begin bad++; $display("FAIL i_bubbles: got %0d idle cycles want %0d", bub, gap_exp); end
    step();
    total++;
    if ({ipf_ctrl, busy, i_src_ready, ipf_i_valid} !== {2'd0, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL drain_entry: got ctrl=%0d busy=%b ir=%b iv=%b want 0 1 0 0", ipf_ctrl, busy, i_src_ready, ipf_i_valid);
    end
    total++;
    if ({ipf_Wsize, ipf_stride} !== {1'b0, ws, st & ~ws}) begin
      bad++;
      $display("FAIL static_cfg: got Wsize=%0d stride=%b want %0d %b", ipf_Wsize, ipf_stride, {1'b0, ws}, st & ~ws);
    end
    total++;
    if (done_n != 0) begin bad++; $display("FAIL early_done: got %0d pulses want 0", done_n); end
    $display("job ws=%0d st=%0d np=%0d: %0d weight words, %0d input words", ws, st, np, cap_w_n, cap_d.size());
  endtask

  // Hold in DRAIN briefly, then complete the job with a one-cycle finish pulse.
  task automatic finish_job();
    repeat (2) step();
    total++;
    if ({done, busy} !== 2'b01) begin bad++; $display("FAIL drain_wait: got done=%b busy=%b want 0 1", done, busy); end
    ipf_finish = 1'b1;
    step();
    ipf_finish = 1'b0;
    total++;
    if ({done, busy, err} !== 3'b100) begin
      bad++;
      $display("FAIL done_pulse: got done=%b busy=%b err=%b want 1 0 0", done, busy, err);
    end
    step();
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL done_width: got %b want 0", done); end
  endtask

  task automatic test_3x3_s1();   run_to_drain(1'b0, 1'b0, 4'd2, -1, 0, 1'b1); finish_job(); endtask
  task automatic test_5x5();      run_to_drain(1'b1, 1'b1, 4'd4, -1, 0, 1'b0); finish_job(); endtask
  task automatic test_3x3_s2();   run_to_drain(1'b0, 1'b1, 4'd1, -1, 0, 1'b0); finish_job(); endtask
  task automatic test_npass0();   run_to_drain(1'b0, 1'b0, 4'd0, -1, 0, 1'b0); finish_job(); endtask
  task automatic test_src_gap();  run_to_drain(1'b0, 1'b0, 4'd1, 7, 3, 1'b0);  finish_job(); endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    cfg_wsize = 1'b0; cfg_stride = 1'b0; cfg_npass = 4'd2;
    w_src_valid = 1'b1; i_src_valid = 1'b1; cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    done_n = 0;
    while (ipf_ctrl !== 2'd1 && n < 200) begin step(); n++; end
    total++;
    if (n >= 200) begin bad++; $display("FAIL reach_run: got no RUN within %0d cycles want RUN", n); end
    repeat (2) step();
    rst = 1'b1;
    step();
    total++;
    if ({w_src_ready, i_src_ready, ipf_ctrl, ipf_w_valid, ipf_i_valid, ipf_w_data, ipf_i_data,
         ipf_Wsize, ipf_stride, ipf_wgroup, ipf_wround, busy, done, err} !== '0) begin
      bad++;
      $display("FAIL abort_outputs: got ctrl=%0d busy=%b iv=%b wg=%0d want all 0", ipf_ctrl, busy, ipf_i_valid, ipf_wgroup);
    end
    rst = 1'b0;
    repeat (4) step();
    total++;
    if (done_n != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_no_done: got done_n=%0d busy=%b want 0 0", done_n, busy);
    end
  endtask

`ifdef IPF_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    run_to_drain(1'b0, 1'b0, 4'd1, -1, 0, 1'b0);
    n = 1;
    while (done !== 1'b1 && n < 1100) begin step(); n++; end
    total++;
    if (n != 1023) begin bad++; $display("FAIL timeout_cycles: got %0d want 1023", n); end
    total++;
    if ({done, err, busy} !== 3'b110) begin bad++; $display("FAIL timeout_flags: got done=%b err=%b busy=%b want 1 1 0", done, err, busy); end
    step();
    total++;
    if ({done, err} !== 2'b01) begin bad++; $display("FAIL err_sticky: got done=%b err=%b want 0 1", done, err); end
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    total++;
    if ({err, busy} !== 2'b01) begin bad++; $display("FAIL err_clear: got err=%b busy=%b want 0 1", err, busy); end
    rst = 1'b1; step(); rst = 1'b0; step();
  endtask
`else
  task automatic test_no_timeout();
    run_to_drain(1'b0, 1'b0, 4'd1, -1, 0, 1'b0);
    repeat (1100) step();
    total++;
    if (done_n != 0 || busy !== 1'b1 || err !== 1'b0) begin
      bad++;
      $display("FAIL drain_forever: got done_n=%0d busy=%b err=%b want 0 1 0", done_n, busy, err);
    end
    finish_job();
  endtask
`endif

  initial begin
    test_reset();
    test_3x3_s1();
    test_5x5();
    test_3x3_s2();
    test_npass0();
    test_src_gap();
    test_reset_mid();
    test_3x3_s1();
`ifdef IPF_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
